arbitro_escrita_registradores: RTL and testbench

Write-port arbiter and scoreboard for the 32×32 register file in the ID stage. It merges write-backs from the in-order WB stage and from the multi-cycle unit (MC: mul/div) onto the register file's single write port. It tracks registers with an MC result still outstanding and stalls ID on any hazard against them. If MC waits too long, it requests a pipeline bubble so MC is not starved.

---
 rtl/arbitro_escrita_registradores.sv | 92 +++++++++
 tb/tb_arbitro_escrita_registradores.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/arbitro_escrita_registradores.sv
// Register file write-port arbiter (WB over MC), MC scoreboard with hazard stall,
// and starvation counter that requests a WB bubble when MC waits too long.
module arbitro_escrita_registradores #(
  parameter int unsigned LIMITE_ESPERA = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_valido,
  input  logic [4:0]  wb_endereco,
  input  logic [31:0] wb_dado,
  input  logic        mc_valido,
  input  logic [4:0]  mc_endereco,
  input  logic [31:0] mc_dado,
  output logic        mc_pronto,
  input  logic        emite_mc,
  input  logic [4:0]  emite_endereco,
  input  logic [4:0]  id_fonte1,
  input  logic [4:0]  id_fonte2,
  input  logic [4:0]  id_destino,
  output logic        habilita_escrita,
  output logic [4:0]  endereco_destino,
  output logic [31:0] dado_escrita,
  output logic        stall_id,
  output logic        pedido_bolha,
  output logic [31:0] pendente
);

  localparam logic [3:0] LIMITE = 4'(LIMITE_ESPERA);

  logic        wb_real;
  logic        escrita_mc;
  logic [31:0] pendente_next;
  logic [3:0]  espera, espera_next;

  assign wb_real   = wb_valido && (wb_endereco != '0);
  assign mc_pronto = mc_valido && !wb_real;

  assign stall_id = pendente[id_fonte1] || pendente[id_fonte2] || pendente[id_destino] ||
                    (emite_mc && pendente[emite_endereco]);

  // escrita_mc remembers the source of the registered write so only MC commits clear the scoreboard
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      habilita_escrita <= 1'b0;
      endereco_destino <= '0;
      dado_escrita     <= '0;
      escrita_mc       <= 1'b0;
    end else if (wb_real) begin
      habilita_escrita <= 1'b1;
      endereco_destino <= wb_endereco;
      dado_escrita     <= wb_dado;
      escrita_mc       <= 1'b0;
    end else if (mc_valido) begin
      habilita_escrita <= (mc_endereco != '0);
      endereco_destino <= mc_endereco;
      dado_escrita     <= mc_dado;
      escrita_mc       <= 1'b1;
    end else begin
      habilita_escrita <= 1'b0;
      escrita_mc       <= 1'b0;
    end
  end

  // Set is applied after clear so a simultaneous issue keeps the bit pending
  always_comb begin
    pendente_next = pendente;
    if (habilita_escrita && escrita_mc)
      pendente_next[endereco_destino] = 1'b0;
    if (emite_mc && (emite_endereco != '0))
      pendente_next[emite_endereco] = 1'b1;
    pendente_next[0] = 1'b0;
  end

  always_comb begin
    espera_next = '0;
    if (mc_valido && !mc_pronto)
      espera_next = (espera >= LIMITE) ? LIMITE : espera + 4'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pendente     <= '0;
      espera       <= '0;
      pedido_bolha <= 1'b0;
    end else begin
      pendente     <= pendente_next;
      espera       <= espera_next;
      pedido_bolha <= (espera_next == LIMITE);
    end
  end

endmodule

// File: tb/tb_arbitro_escrita_registradores.sv
// Directed self-checking bench for arbitro_escrita_registradores.
module tb_arbitro_escrita_registradores;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_valido;
  logic [4:0]  wb_endereco;
  logic [31:0] wb_dado;
  logic        mc_valido;
  logic [4:0]  mc_endereco;
  logic [31:0] mc_dado;
  logic        mc_pronto;
  logic        emite_mc;
  logic [4:0]  emite_endereco;
  logic [4:0]  id_fonte1, id_fonte2, id_destino;
  logic        habilita_escrita;
  logic [4:0]  endereco_destino;
  logic [31:0] dado_escrita;
  logic        stall_id;
  logic        pedido_bolha;
  logic [31:0] pendente;

  int checks = 0;
  int errors = 0;

  arbitro_escrita_registradores #(.LIMITE_ESPERA(4)) dut (
    .clk(clk), .reset(reset),
    .wb_valido(wb_valido), .wb_endereco(wb_endereco), .wb_dado(wb_dado),
    .mc_valido(mc_valido), .mc_endereco(mc_endereco), .mc_dado(mc_dado),
    .mc_pronto(mc_pronto),
    .emite_mc(emite_mc), .emite_endereco(emite_endereco),
    .id_fonte1(id_fonte1), .id_fonte2(id_fonte2), .id_destino(id_destino),
    .habilita_escrita(habilita_escrita), .endereco_destino(endereco_destino),
    .dado_escrita(dado_escrita), .stall_id(stall_id),
    .pedido_bolha(pedido_bolha), .pendente(pendente)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 ns after the next rising edge; inputs change there, combinational checks at +1 more
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    wb_valido = 0; wb_endereco = '0; wb_dado = '0;
    mc_valido = 0; mc_endereco = '0; mc_dado = '0;
    emite_mc = 0; emite_endereco = '0;
    id_fonte1 = '0; id_fonte2 = '0; id_destino = '0;
    #12;
    chk("reset_hab", 32'(habilita_escrita), 0);
    chk("reset_end", 32'(endereco_destino), 0);
    chk("reset_dado", dado_escrita, 0);
    chk("reset_pend", pendente, 0);
    chk("reset_bolha", 32'(pedido_bolha), 0);
    chk("reset_stall", 32'(stall_id), 0);
    tick();
    reset = 1'b0;

    // Collision: WB x5 wins, MC x7 waits one cycle
    wb_valido = 1; wb_endereco = 5; wb_dado = 32'h11;
    mc_valido = 1; mc_endereco = 7; mc_dado = 32'h22;
    #1 chk("col_pronto0", 32'(mc_pronto), 0);
    tick();
    chk("col_wb_hab", 32'(habilita_escrita), 1);
    chk("col_wb_end", 32'(endereco_destino), 5);
    chk("col_wb_dado", dado_escrita, 32'h11);
    wb_valido = 0;
    #1 chk("col_pronto1", 32'(mc_pronto), 1);
    tick();
    chk("col_mc_hab", 32'(habilita_escrita), 1);
    chk("col_mc_end", 32'(endereco_destino), 7);
    chk("col_mc_dado", dado_escrita, 32'h22);
    chk("col_no_pend", pendente, 0);
    mc_valido = 0;
    tick();
    chk("idle_hab", 32'(habilita_escrita), 0);
    chk("idle_hold_end", 32'(endereco_destino), 7);
    chk("idle_hold_dado", dado_escrita, 32'h22);

    // Scoreboard: x9 pending until its MC commit edge
    emite_mc = 1; emite_endereco = 9; id_fonte2 = 9;
    #1 chk("sb_stall_pre", 32'(stall_id), 0);
    tick();
    emite_mc = 0;
    #1 chk("sb_pend9", pendente, 32'h200);
    chk("sb_stall1", 32'(stall_id), 1);
    tick();
    mc_valido = 1; mc_endereco = 9; mc_dado = 32'h99;
    #1 chk("sb_pronto", 32'(mc_pronto), 1);
    chk("sb_stallN", 32'(stall_id), 1);
    tick();
    mc_valido = 0;
    #1 chk("sb_hab9", 32'(habilita_escrita), 1);
    chk("sb_pend_N1", pendente, 32'h200);
    chk("sb_stallN1", 32'(stall_id), 1);
    tick();
    chk("sb_pend_clr", pendente, 0);
    chk("sb_stallN2", 32'(stall_id), 0);
    id_fonte2 = 0;

    // Set/clear race on x4
    emite_mc = 1; emite_endereco = 4;
    tick();
    emite_mc = 0;
    mc_valido = 1; mc_endereco = 4; mc_dado = 32'h44;
    id_destino = 4;
    #1 chk("race_stall_dest", 32'(stall_id), 1);
    tick();
    mc_valido = 0; id_destino = 0;
    emite_mc = 1; emite_endereco = 4;
    #1 chk("race_hab4", 32'(habilita_escrita), 1);
    chk("race_stall_emite", 32'(stall_id), 1);
    tick();
    emite_mc = 0;
    #1 chk("race_pend4", pendente, 32'h10);
    mc_valido = 1; mc_endereco = 4; mc_dado = 32'h45;
    tick();
    mc_valido = 0;
    tick();
    chk("race_cleanup", pendente, 0);

    // x0 handling
    mc_valido = 1; mc_endereco = 0; mc_dado = 32'h55;
    #1 chk("x0_mc_pronto", 32'(mc_pronto), 1);
    tick();
    chk("x0_mc_hab", 32'(habilita_escrita), 0);
    wb_valido = 1; wb_endereco = 0; wb_dado = 32'hAA;
    mc_endereco = 3; mc_dado = 32'h33;
    #1 chk("x0_wb_pronto", 32'(mc_pronto), 1);
    tick();
    chk("x0_x3_hab", 32'(habilita_escrita), 1);
    chk("x0_x3_end", 32'(endereco_destino), 3);
    chk("x0_x3_dado", dado_escrita, 32'h33);
    wb_valido = 0; mc_valido = 0;
    tick();

    // Starvation: WB to x1 every cycle while MC x8 waits
    wb_valido = 1; wb_endereco = 1;
    mc_valido = 1; mc_endereco = 8; mc_dado = 32'h88;
    for (int k = 1; k <= 4; k++) begin
      wb_dado = 32'(k);
      #1 chk("starve_pronto", 32'(mc_pronto), 0);
      tick();
      chk("starve_bolha", 32'(pedido_bolha), (k >= 4) ? 1 : 0);
      chk("starve_wb_end", 32'(endereco_destino), 1);
    end
    wb_valido = 0;
    #1 chk("bubble_pronto", 32'(mc_pronto), 1);
    chk("bubble_bolha_hi", 32'(pedido_bolha), 1);
    tick();
    chk("bubble_bolha_lo", 32'(pedido_bolha), 0);
    chk("bubble_hab", 32'(habilita_escrita), 1);
    chk("bubble_end", 32'(endereco_destino), 8);
    chk("bubble_dado", dado_escrita, 32'h88);
    mc_valido = 0;

    // Reset mid-operation drops an accepted write and pending bits
    emite_mc = 1; emite_endereco = 10;
    tick();
    emite_mc = 0;
    mc_valido = 1; mc_endereco = 10; mc_dado = 32'hA0;
    tick();
    mc_valido = 0;
    #1 chk("mid_hab_pre", 32'(habilita_escrita), 1);
    #1 reset = 1'b1;
    #1 chk("mid_hab", 32'(habilita_escrita), 0);
    chk("mid_end", 32'(endereco_destino), 0);
    chk("mid_dado", dado_escrita, 0);
    chk("mid_pend", pendente, 0);
    chk("mid_bolha", 32'(pedido_bolha), 0);
    tick();
    reset = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
